// File: rtl/core_pkg.sv
`default_nettype none
// ============================================================================
// Module      : core_pkg
// Description : Shared types and constants for the store operand collector.
// Revision    : 1.0 - initial release
// ============================================================================
package core_pkg;

    localparam int NrLane         = 4;
    localparam int VrfDataW       = 64;
    localparam int InsnIdW        = 4;
    localparam int StoreBeatW     = 16;
    localparam int StoreFifoDepth = 2;

    typedef logic [VrfDataW-1:0] vrf_data_t;
    typedef logic [InsnIdW-1:0]  insn_id_t;

    typedef struct packed {
        insn_id_t              id;
        logic [StoreBeatW-1:0] beats;
    } store_req_t;

    localparam logic [1:0] c_ST_IDLE    = 2'd0;
    localparam logic [1:0] c_ST_COLLECT = 2'd1;
    localparam logic [1:0] c_ST_DRAIN   = 2'd2;
    localparam logic [1:0] c_ST_DONE    = 2'd3;

endpackage
`default_nettype wire

// File: rtl/store_beat_fifo.sv
`default_nettype none
// ============================================================================
// Module      : store_beat_fifo
// Description : Power-of-two beat buffer carrying data plus a last flag.
// Revision    : 1.0 - initial release
// ============================================================================
module store_beat_fifo #(
    parameter int DATA_W = 256,
    parameter int DEPTH  = 2
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [DATA_W-1:0] in_data_i,
    input  logic              in_last_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [DATA_W-1:0] out_data_o,
    output logic              out_last_o
);

    localparam int c_PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int c_CNT_W = c_PTR_W + 1;

    logic [DATA_W:0]    r_mem [DEPTH];
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [c_CNT_W-1:0] r_count;
    logic               w_push;
    logic               w_pop;

    // Ready is derived from the registered count only, so a pop never frees a slot in the same cycle.
    assign in_ready_o  = (r_count != c_CNT_W'(DEPTH));
    assign out_valid_o = (r_count != '0);
    assign w_push      = in_valid_i & in_ready_o;
    assign w_pop       = out_valid_o & out_ready_i;
    assign out_data_o  = r_mem[r_rd_ptr][DATA_W-1:0];
    assign out_last_o  = r_mem[r_rd_ptr][DATA_W];

    always_ff @(posedge clk_i) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= {in_last_i, in_data_i};
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_CNT_W'(1);
                2'b01:   r_count <= r_count - c_CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/store_op_collector.sv
`default_nettype none
// ============================================================================
// Module      : store_op_collector
// Description : Gathers per-lane store operands into memory write beats.
//               Optional macro STORE_OP_COLLECTOR_STALL_CNT_EN adds a
//               saturating write-stall cycle counter output.
// Revision    : 1.0 - initial release
// ============================================================================
module store_op_collector
    import core_pkg::*;
#(
    parameter int FifoDepth = StoreFifoDepth
) (
    input  logic                                clk_i,
    input  logic                                rst_i,
    input  logic                                store_req_valid_i,
    output logic                                store_req_ready_o,
    input  store_req_t                          store_req_i,
    input  logic [NrLane-1:0]                   store_op_valid_i,
    output logic [NrLane-1:0]                   store_op_ready_o,
    input  vrf_data_t [NrLane-1:0]              store_op_i,
    output logic                                mem_w_valid_o,
    input  logic                                mem_w_ready_i,
    output logic [NrLane*$bits(vrf_data_t)-1:0] mem_w_data_o,
    output logic                                mem_w_last_o,
    output logic                                store_done_o,
    output insn_id_t                            store_done_id_o,
    input  logic                                store_done_gnt_i
`ifdef STORE_OP_COLLECTOR_STALL_CNT_EN
    ,
    output logic [31:0]                         perf_stall_cnt_o
`endif
);

    localparam int c_VW     = $bits(vrf_data_t);
    localparam int c_BEAT_W = NrLane * c_VW;

    logic [1:0]            r_state;
    logic [1:0]            w_state_next;
    insn_id_t              r_id;
    logic [StoreBeatW-1:0] r_remaining;
    logic [NrLane-1:0]     r_full;
    vrf_data_t             r_hold [NrLane];

    logic                  w_accept;
    logic                  w_collect;
    logic                  w_push;
    logic                  w_pop;
    logic                  w_is_last;
    logic                  w_more;
    logic [NrLane-1:0]     w_capture;
    logic [c_BEAT_W-1:0]   w_beat;
    logic                  w_fifo_in_ready;
    logic                  w_fifo_out_valid;
    logic                  w_fifo_out_last;

    assign store_req_ready_o = (r_state == c_ST_IDLE);
    assign w_accept          = store_req_valid_i & store_req_ready_o;
    assign w_collect         = (r_state == c_ST_COLLECT);
    assign w_push            = w_collect & (&r_full) & w_fifo_in_ready;
    assign w_is_last         = (r_remaining == StoreBeatW'(1));
    assign w_more            = (r_remaining > StoreBeatW'(1));
    assign w_pop             = w_fifo_out_valid & mem_w_ready_i;
    assign store_done_o      = (r_state == c_ST_DONE);
    assign store_done_id_o   = r_id;
    assign mem_w_valid_o     = w_fifo_out_valid;
    assign mem_w_last_o      = w_fifo_out_valid & w_fifo_out_last;

    // A lane may refill in the push cycle only if another beat is still owed.
    for (genvar g = 0; g < NrLane; g++) begin : g_lane
        assign store_op_ready_o[g] = w_collect & (~r_full[g] | (w_push & w_more));
        assign w_capture[g]        = store_op_valid_i[g] & store_op_ready_o[g];
    end

    always_comb begin
        w_beat = '0;
        for (int i = 0; i < NrLane; i++) begin
            w_beat[i*c_VW +: c_VW] = r_hold[i];
        end
    end

    always_ff @(posedge clk_i) begin
        for (int i = 0; i < NrLane; i++) begin
            if (w_capture[i]) begin
                r_hold[i] <= store_op_i[i];
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_full <= '0;
        end else begin
            for (int i = 0; i < NrLane; i++) begin
                if (w_capture[i]) begin
                    r_full[i] <= 1'b1;
                end else if (w_push) begin
                    r_full[i] <= 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state     <= c_ST_IDLE;
            r_id        <= '0;
            r_remaining <= '0;
        end else begin
            r_state <= w_state_next;
            if (w_accept) begin
                r_id        <= store_req_i.id;
                r_remaining <= store_req_i.beats;
            end else if (w_push) begin
                r_remaining <= r_remaining - StoreBeatW'(1);
            end
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_ST_IDLE: begin
                if (w_accept) begin
                    w_state_next = (store_req_i.beats == '0) ? c_ST_DONE : c_ST_COLLECT;
                end
            end
            c_ST_COLLECT: begin
                if (w_push && w_is_last) begin
                    w_state_next = c_ST_DRAIN;
                end
            end
            c_ST_DRAIN: begin
                if (w_pop && w_fifo_out_last) begin
                    w_state_next = c_ST_DONE;
                end
            end
            c_ST_DONE: begin
                if (store_done_gnt_i) begin
                    w_state_next = c_ST_IDLE;
                end
            end
            default: w_state_next = c_ST_IDLE;
        endcase
    end

    store_beat_fifo #(
        .DATA_W (c_BEAT_W),
        .DEPTH  (FifoDepth)
    ) u_fifo (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .in_valid_i  (w_push),
        .in_ready_o  (w_fifo_in_ready),
        .in_data_i   (w_beat),
        .in_last_i   (w_is_last),
        .out_valid_o (w_fifo_out_valid),
        .out_ready_i (mem_w_ready_i),
        .out_data_o  (mem_w_data_o),
        .out_last_o  (w_fifo_out_last)
    );

`ifdef STORE_OP_COLLECTOR_STALL_CNT_EN
    logic [31:0] r_stall_cnt;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_stall_cnt <= '0;
        end else if (mem_w_valid_o && !mem_w_ready_i && !(&r_stall_cnt)) begin
            r_stall_cnt <= r_stall_cnt + 32'd1;
        end
    end

    assign perf_stall_cnt_o = r_stall_cnt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_store_op_collector.sv
`default_nettype none
// ============================================================================
// Module      : tb_store_op_collector
// Description : Directed self-checking bench for store_op_collector.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_store_op_collector;
    import core_pkg::*;

    localparam int BW = NrLane * $bits(vrf_data_t);

    logic                  clk_i;
    logic                  rst_i;
    logic                  store_req_valid_i;
    logic                  store_req_ready_o;
    store_req_t            store_req_i;
    logic [NrLane-1:0]     store_op_valid_i;
    logic [NrLane-1:0]     store_op_ready_o;
    vrf_data_t [NrLane-1:0] store_op_i;
    logic                  mem_w_valid_o;
    logic                  mem_w_ready_i;
    logic [BW-1:0]         mem_w_data_o;
    logic                  mem_w_last_o;
    logic                  store_done_o;
    insn_id_t              store_done_id_o;
    logic                  store_done_gnt_i;
`ifdef STORE_OP_COLLECTOR_STALL_CNT_EN
    logic [31:0]           perf_stall_cnt_o;
`endif

    int checks   = 0;
    int failures = 0;
    logic [BW:0] obs_q [$];

    store_op_collector dut (
        .clk_i             (clk_i),
        .rst_i             (rst_i),
        .store_req_valid_i (store_req_valid_i),
        .store_req_ready_o (store_req_ready_o),
        .store_req_i       (store_req_i),
        .store_op_valid_i  (store_op_valid_i),
        .store_op_ready_o  (store_op_ready_o),
        .store_op_i        (store_op_i),
        .mem_w_valid_o     (mem_w_valid_o),
        .mem_w_ready_i     (mem_w_ready_i),
        .mem_w_data_o      (mem_w_data_o),
        .mem_w_last_o      (mem_w_last_o),
        .store_done_o      (store_done_o),
        .store_done_id_o   (store_done_id_o),
        .store_done_gnt_i  (store_done_gnt_i)
`ifdef STORE_OP_COLLECTOR_STALL_CNT_EN
        ,
        .perf_stall_cnt_o  (perf_stall_cnt_o)
`endif
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    // Record every accepted memory beat as {last, data}.
    always @(negedge clk_i) begin
        if (!rst_i && mem_w_valid_o && mem_w_ready_i) begin
            obs_q.push_back({mem_w_last_o, mem_w_data_o});
        end
    end

    function automatic vrf_data_t lane_word(input int beat, input int lane);
        return 64'hC0DE_0000_0000_0000 | (64'(beat) << 16) | 64'(lane);
    endfunction

    function automatic logic [BW-1:0] beat_word(input int beat);
        logic [BW-1:0] w;
        w = '0;
        for (int l = 0; l < NrLane; l++) begin
            w[l*64 +: 64] = lane_word(beat, l);
        end
        return w;
    endfunction

    task automatic check(input string tag, input logic [BW:0] obs, input logic [BW:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic neg();
        @(negedge clk_i);
    endtask

    task automatic drive_lanes(input int beat, input logic [NrLane-1:0] v);
        store_op_valid_i = v;
        for (int l = 0; l < NrLane; l++) begin
            store_op_i[l] = lane_word(beat, l);
        end
    endtask

    task automatic request(input logic [3:0] id, input logic [15:0] beats);
        store_req_i.id    = id;
        store_req_i.beats = beats;
        store_req_valid_i = 1'b1;
    endtask

    // Called at a negedge while done is expected; returns after the grant edge.
    task automatic grant();
        store_done_gnt_i = 1'b1;
        tick();
        store_done_gnt_i = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        for (int i = 0; i < 40; i++) begin
            if (store_done_o) break;
            neg();
        end
        check(tag, store_done_o, 1'b1);
    endtask

    initial begin
        rst_i             = 1'b1;
        store_req_valid_i = 1'b0;
        store_req_i       = '0;
        store_op_valid_i  = '0;
        store_op_i        = '0;
        mem_w_ready_i     = 1'b1;
        store_done_gnt_i  = 1'b0;

        // Reset values
        repeat (3) tick();
        neg();
        check("rst_req_ready", store_req_ready_o, 1'b1);
        check("rst_op_ready", store_op_ready_o, 4'h0);
        check("rst_mem_valid", mem_w_valid_o, 1'b0);
        check("rst_mem_last", mem_w_last_o, 1'b0);
        check("rst_done", store_done_o, 1'b0);
        rst_i = 1'b0;
        tick();

        // Nominal: 3 beats, lanes always valid, memory always ready
        obs_q.delete();
        request(4'd5, 16'd3);
        drive_lanes(0, 4'hF);
        tick();
        store_req_valid_i = 1'b0;
        neg();
        check("nom_op_ready", store_op_ready_o, 4'hF);
        check("nom_req_busy", store_req_ready_o, 1'b0);
        tick();
        drive_lanes(1, 4'hF);
        neg();
        check("nom_ready_on_push", store_op_ready_o, 4'hF);
        check("nom_lat0", mem_w_valid_o, 1'b0);
        tick();
        drive_lanes(2, 4'hF);
        neg();
        check("nom_lat1", mem_w_valid_o, 1'b1);
        tick();
        neg();
        check("nom_ready_final", store_op_ready_o, 4'h0);
        neg();
        check("nom_last_flag", {mem_w_valid_o, mem_w_last_o}, 2'b11);
        neg();
        check("nom_done", store_done_o, 1'b1);
        check("nom_done_id", store_done_id_o, 4'd5);
        grant();
        drive_lanes(0, 4'h0);
        neg();
        check("nom_idle_ready", store_req_ready_o, 1'b1);
        check("nom_done_clear", store_done_o, 1'b0);
        check("nom_beat_cnt", obs_q.size(), 3);
        for (int k = 0; k < 3; k++) begin
            check("nom_beat", obs_q[k], {(k == 2), beat_word(k)});
        end

        // Skew: lane 2 arrives late
        tick();
        obs_q.delete();
        request(4'd2, 16'd1);
        store_op_valid_i = 4'b1011;
        store_op_i[0] = 64'hAAAA_AAAA_AAAA_AAAA;
        store_op_i[1] = 64'hAAAA_AAAA_AAAA_AAAA;
        store_op_i[2] = 64'h2222_2222_2222_2222;
        store_op_i[3] = 64'hAAAA_AAAA_AAAA_AAAA;
        tick();
        store_req_valid_i = 1'b0;
        tick();
        for (int i = 0; i < 3; i++) begin
            neg();
            check("skew_ready", store_op_ready_o, 4'b0100);
            check("skew_no_push", mem_w_valid_o, 1'b0);
            tick();
        end
        store_op_valid_i = 4'b1111;
        tick();
        store_op_valid_i = 4'b0000;
        neg();
        check("skew_push_lat", mem_w_valid_o, 1'b0);
        neg();
        check("skew_beat", {mem_w_valid_o, mem_w_last_o, mem_w_data_o},
              {2'b11, 64'hAAAA_AAAA_AAAA_AAAA, 64'h2222_2222_2222_2222,
               64'hAAAA_AAAA_AAAA_AAAA, 64'hAAAA_AAAA_AAAA_AAAA});
        neg();
        check("skew_done_id", {store_done_o, store_done_id_o}, {1'b1, 4'd2});
        grant();

        // Backpressure: memory stalls 10 cycles, 4 beats
        obs_q.delete();
        mem_w_ready_i = 1'b0;
        request(4'd7, 16'd4);
        drive_lanes(0, 4'hF);
        tick();
        store_req_valid_i = 1'b0;
        tick();
        drive_lanes(1, 4'hF);
        tick();
        drive_lanes(2, 4'hF);
        tick();
        drive_lanes(3, 4'hF);
        neg();
        check("bp_lanes_held", store_op_ready_o, 4'h0);
        check("bp_head", {mem_w_valid_o, mem_w_last_o, mem_w_data_o}, {2'b10, beat_word(0)});
        repeat (8) tick();
        neg();
        check("bp_stable", {mem_w_valid_o, mem_w_data_o}, {1'b1, beat_word(0)});
        check("bp_still_held", store_op_ready_o, 4'h0);
        tick();
        mem_w_ready_i = 1'b1;
        neg();
`ifdef STORE_OP_COLLECTOR_STALL_CNT_EN
        check("bp_stall_cnt", perf_stall_cnt_o, 32'd10);
`endif
        wait_done("bp_done");
        check("bp_done_id", store_done_id_o, 4'd7);
        grant();
        drive_lanes(0, 4'h0);
        check("bp_beat_cnt", obs_q.size(), 4);
        for (int k = 0; k < 4; k++) begin
            check("bp_beat", obs_q[k], {(k == 3), beat_word(k)});
        end

        // Zero length with delayed grant
        obs_q.delete();
        request(4'd9, 16'd0);
        tick();
        store_req_valid_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            neg();
            check("zero_done_held", {store_done_o, store_done_id_o, mem_w_valid_o}, {1'b1, 4'd9, 1'b0});
            if (i == 2) store_done_gnt_i = 1'b1;
            tick();
        end
        store_done_gnt_i = 1'b0;
        neg();
        check("zero_back_idle", {store_done_o, store_req_ready_o}, 2'b01);
        check("zero_no_beats", obs_q.size(), 0);

        // Reset after the first of three beats
        tick();
        obs_q.delete();
        request(4'd6, 16'd3);
        drive_lanes(0, 4'hF);
        tick();
        store_req_valid_i = 1'b0;
        tick();
        drive_lanes(1, 4'hF);
        tick();
        drive_lanes(2, 4'hF);
        tick();
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
        drive_lanes(0, 4'h0);
        neg();
        check("mid_rst_outputs",
              {store_req_ready_o, store_op_ready_o, mem_w_valid_o, mem_w_last_o, store_done_o},
              {1'b1, 4'h0, 3'b000});
        check("mid_rst_one_beat", obs_q.size(), 1);
        tick();
        obs_q.delete();
        request(4'd11, 16'd1);
        drive_lanes(5, 4'hF);
        tick();
        store_req_valid_i = 1'b0;
        tick();
        drive_lanes(0, 4'h0);
        tick();
        neg();
        check("post_rst_beat", {mem_w_valid_o, mem_w_last_o, mem_w_data_o}, {2'b11, beat_word(5)});
        neg();
        check("post_rst_done", {store_done_o, store_done_id_o}, {1'b1, 4'd11});
        grant();

        // Back-to-back: next request waits through DONE
        obs_q.delete();
        request(4'd3, 16'd0);
        tick();
        request(4'd4, 16'd1);
        neg();
        check("b2b_done_busy", {store_done_o, store_done_id_o, store_req_ready_o}, {1'b1, 4'd3, 1'b0});
        grant();
        neg();
        check("b2b_idle", {store_req_ready_o, store_done_o}, 2'b10);
        tick();
        store_req_valid_i = 1'b0;
        drive_lanes(6, 4'hF);
        neg();
        check("b2b_accepted", {store_req_ready_o, store_op_ready_o}, {1'b0, 4'hF});
        tick();
        drive_lanes(0, 4'h0);
        neg();
        wait_done("b2b_done");
        check("b2b_done_id", store_done_id_o, 4'd4);
        grant();
        check("b2b_beat", obs_q.size() == 1 ? obs_q[0] : '0, {1'b1, beat_word(6)});

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
